// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, single-outstanding instruction fetch, one-entry stall buffer.
// Define FETCH_SCAN_EN to add the cycle counter and per-cycle scan print.
module fetch_pc_unit #(
   parameter int CORE            = 0,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDRESS_BITS    = 20,
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDRESS_BITS-1:0] program_address,
   input  logic [1:0]              next_PC_sel,
   input  logic [ADDRESS_BITS-1:0] target_PC,
   input  logic                    i_mem_read,
   output logic                    instruction_read,
   output logic [ADDRESS_BITS-1:0] instruction_read_address,
   input  logic                    instruction_ready,
   input  logic [DATA_WIDTH-1:0]   instruction_in,
   input  logic                    instruction_valid,
   output logic [DATA_WIDTH-1:0]   instruction_decode,
   output logic [ADDRESS_BITS-1:0] inst_PC_decode,
   output logic                    fetch_valid,
   output logic                    i_mem_hazard,
   input  logic                    scan
);
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REDIRECT_WAIT} state_t;

   state_t                  r_state, w_next;
   logic [ADDRESS_BITS-1:0] r_pc, r_buf_pc, r_dec_pc;
   logic [DATA_WIDTH-1:0]   r_buf_inst, r_dec_inst;
   logic                    r_buf_valid, r_fetch_valid;
   logic                    w_redirect, w_accept, w_resp, w_deliver_resp, w_deliver_buf, w_capture;

   assign w_redirect     = r_state != IDLE && next_PC_sel == 2'b10;
   assign w_accept       = instruction_read && instruction_ready;
   assign w_resp         = r_state == WAIT && instruction_valid;
   assign w_deliver_resp = w_resp && !w_redirect && i_mem_read;
   assign w_capture      = w_resp && !w_redirect && !i_mem_read;
   assign w_deliver_buf  = r_buf_valid && !w_redirect && i_mem_read;

   // State register
   always_ff @(posedge clock or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;

   // Next state: a redirect with a request in flight must swallow its response first
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:          w_next = start ? ISSUE : IDLE;
         ISSUE:         w_next = w_accept ? (w_redirect ? REDIRECT_WAIT : WAIT) : ISSUE;
         WAIT:          w_next = instruction_valid ? ISSUE : (w_redirect ? REDIRECT_WAIT : WAIT);
         REDIRECT_WAIT: w_next = instruction_valid ? ISSUE : REDIRECT_WAIT;
         default:       w_next = IDLE;
      endcase
   end

   // Outputs: request only while the buffer has room; decode shows NOP on bubbles
   always_comb begin
      instruction_read         = r_state == ISSUE && !r_buf_valid;
      instruction_read_address = instruction_read ? r_pc : '0;
      instruction_decode       = r_fetch_valid ? r_dec_inst : NOP;
      inst_PC_decode           = r_dec_pc;
      fetch_valid              = r_fetch_valid;
      i_mem_hazard             = r_state != ISSUE || !instruction_ready || !r_fetch_valid;
   end

   // PC, stall buffer and registered decode stage
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_pc          <= '0;
         r_buf_valid   <= 1'b0;
         r_buf_inst    <= NOP;
         r_buf_pc      <= '0;
         r_dec_inst    <= NOP;
         r_dec_pc      <= '0;
         r_fetch_valid <= 1'b0;
      end else begin
         if (w_redirect) r_pc <= target_PC;
         else if (r_state == IDLE && start) r_pc <= program_address;
         else if (w_resp && next_PC_sel == 2'b00) r_pc <= r_pc + ADDRESS_BITS'(4);
         if (w_redirect) r_buf_valid <= 1'b0;
         else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf_inst  <= instruction_in;
            r_buf_pc    <= r_pc;
         end else if (w_deliver_buf) r_buf_valid <= 1'b0;
         r_fetch_valid <= w_deliver_resp || w_deliver_buf;
         if (w_deliver_resp) begin
            r_dec_inst <= instruction_in;
            r_dec_pc   <= r_pc;
         end else if (w_deliver_buf) begin
            r_dec_inst <= r_buf_inst;
            r_dec_pc   <= r_buf_pc;
         end
      end

`ifdef FETCH_SCAN_EN
   logic [31:0] r_cycles;

   // Free-running cycle count that bounds the scan print window
   always_ff @(posedge clock or posedge reset)
      if (reset) r_cycles <= '0;
      else r_cycles <= r_cycles + 32'd1;

   // Per-cycle trace of the fetch state while scan is enabled
   always_ff @(posedge clock)
      if (scan && r_cycles >= 32'(SCAN_CYCLES_MIN) && r_cycles <= 32'(SCAN_CYCLES_MAX))
         $display("core %0d fetch: cycle %0d state %0d pc %h sel %b target %h buf %0b hazard %0b",
                  CORE, r_cycles, r_state, r_pc, next_PC_sel, target_PC, r_buf_valid, i_mem_hazard);
`else
   logic w_unused;
   assign w_unused = scan ^ ((CORE + SCAN_CYCLES_MIN + SCAN_CYCLES_MAX) > 0);
`endif
endmodule
